// File: rtl/sword_key_matrix_scan.sv
// sword_key_matrix_scan: scans the 5x4 key matrix, debounces each key and reports new presses as key codes.
// Define KEY_EVENT_FIFO_EN to queue press events in a FIFO_DEPTH-entry FIFO instead of pulsing key_valid.
module sword_key_matrix_scan #(
   parameter int SETTLE_CYCLES  = 5000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   output logic [4:0]  btn_x,
   input  logic [3:0]  btn_y,
   output logic [19:0] result,
   output logic        key_valid,
   output logic [4:0]  key_code,
   input  logic        key_pop,
   output logic        key_ovf
);
   localparam int SW = $clog2(SETTLE_CYCLES);
   typedef enum logic [1:0] {SETTLE, SAMPLE, ADVANCE} state_t;
   state_t        state;
   logic [SW-1:0] settle_cnt;
   logic [2:0]    col, samp_col;
   logic [3:0]    y_meta, y_sync, pending;
   logic [3:0]    deb_cnt [20];
   logic [3:0]    samp, differ, flip, press, m, lo;
   logic [4:0]    base, code;
   logic [1:0]    row;
   logic          issue;
   // Presses found in SAMPLE issue on that same edge, so the first event is visible the cycle after SAMPLE.
   always_comb begin
      base = {col, 2'b00};
      for (int r = 0; r < 4; r++) begin
         samp[r]   = ~y_sync[r];
         differ[r] = samp[r] != result[base + 5'(r)];
         flip[r]   = differ[r] && ({1'b0, deb_cnt[base + 5'(r)]} + 5'd1 == 5'(DEBOUNCE_SCANS));
      end
      press = flip & samp;
      m     = state == SAMPLE ? press : pending;
      lo    = m & (~m + 4'd1);
      row   = m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
      issue = |m;
      code  = {state == SAMPLE ? col : samp_col, row};
   end
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         state      <= SETTLE;
         settle_cnt <= '0;
         col        <= '0;
         samp_col   <= '0;
         btn_x      <= 5'b11110;
         y_meta     <= '1;
         y_sync     <= '1;
         pending    <= '0;
         result     <= '0;
         for (int k = 0; k < 20; k++) deb_cnt[k] <= '0;
      end else begin
         y_meta  <= btn_y;
         y_sync  <= y_meta;
         pending <= m & ~lo;
         if (state == SETTLE) begin
            settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state <= SAMPLE;
         end else if (state == SAMPLE) begin
            samp_col <= col;
            for (int r = 0; r < 4; r++)
               if (!differ[r]) deb_cnt[base + 5'(r)] <= '0;
               else if (flip[r]) begin
                  deb_cnt[base + 5'(r)] <= '0;
                  result[base + 5'(r)]  <= samp[r];
               end else deb_cnt[base + 5'(r)] <= deb_cnt[base + 5'(r)] + 4'd1;
            state <= ADVANCE;
         end else begin
            col        <= col == 3'd4 ? 3'd0 : col + 3'd1;
            btn_x      <= col == 3'd4 ? 5'b11110 : {btn_x[3:0], 1'b1};
            settle_cnt <= '0;
            state      <= SETTLE;
         end
      end
`ifdef KEY_EVENT_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [4:0]    fifo [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          pop, push_ok;
   // A push into a full FIFO still lands when the head leaves on the same edge.
   assign pop       = key_pop && count != '0;
   assign push_ok   = issue && (count != (AW+1)'(FIFO_DEPTH) || pop);
   assign key_valid = count != '0;
   assign key_code  = fifo[rd_ptr];
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         key_ovf <= 1'b0;
         for (int k = 0; k < FIFO_DEPTH; k++) fifo[k] <= '0;
      end else begin
         if (push_ok) begin
            fifo[wr_ptr] <= code;
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (issue && !push_ok) key_ovf <= 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
      end
`else
   logic unused_pop;
   assign unused_pop = key_pop | (FIFO_DEPTH < 1);
   assign key_ovf    = 1'b0;
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         key_valid <= 1'b0;
         key_code  <= '0;
      end else begin
         key_valid <= issue;
         if (issue) key_code <= code;
      end
`endif
endmodule

// File: tb/tb_sword_key_matrix_scan.sv
// tb_sword_key_matrix_scan: random and directed key-matrix stimulus checked against a per-scan behavioural model.
module tb_sword_key_matrix_scan;
   localparam int DB = 4;
   typedef struct {int code; int t;} ev_t;
   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [4:0]  btn_x;
   logic [3:0]  btn_y;
   logic [19:0] result;
   logic        key_valid;
   logic [4:0]  key_code;
   logic        key_pop;
   logic        key_ovf;
   logic [19:0] pressed = '0;
   logic [19:0] mstate;
   int          mrun [20];
   int          cyc;
   bit          hold_pop = 1'b0;
   int          checks = 0;
   int          passed = 0;
   ev_t         exp_q [$];
   ev_t         got_q [$];

   sword_key_matrix_scan #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(DB), .FIFO_DEPTH(8)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .btn_x(btn_x), .btn_y(btn_y), .result(result),
      .key_valid(key_valid), .key_code(key_code), .key_pop(key_pop), .key_ovf(key_ovf)
   );

   always #5 HCLK = ~HCLK;

   // Diode-less matrix: a pressed key pulls its row low while its column is driven.
   always_comb begin
      btn_y = '1;
      for (int c = 0; c < 5; c++)
         for (int r = 0; r < 4; r++)
            if (!btn_x[c] && pressed[c*4+r]) btn_y[r] = 1'b0;
   end

   assign key_pop = HRESETn && key_valid && !hold_pop;

   always @(posedge HCLK or negedge HRESETn) cyc <= !HRESETn ? 0 : cyc + 1;

   function automatic ev_t mk(input int c, input int t);
      ev_t e;
      e.code = c;
      e.t = t;
      return e;
   endfunction

   always @(negedge HCLK)
      if (HRESETn && key_valid && !hold_pop) got_q.push_back(mk(int'(key_code), cyc));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
   endtask

   task automatic clear_model();
      mstate = '0;
      for (int k = 0; k < 20; k++) mrun[k] = 0;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      clear_model();
   endtask

   // One full scan of the physical key state: a key flips after DB consecutive disagreeing scans.
   task automatic model_scan();
      int j, idx, k;
      j = cyc / 30;
      for (int c = 0; c < 5; c++) begin
         idx = 0;
         for (int r = 0; r < 4; r++) begin
            k = c*4 + r;
            if (pressed[k] == mstate[k]) mrun[k] = 0;
            else begin
               mrun[k]++;
               if (mrun[k] == DB) begin
                  mstate[k] = ~mstate[k];
                  mrun[k] = 0;
                  if (mstate[k]) begin
                     exp_q.push_back(mk(k, 30*j + 6*c + 5 + idx));
                     idx++;
                  end
               end
            end
         end
      end
   endtask

   task automatic check_events();
      ev_t e, g;
      while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
         e = exp_q.pop_front();
         g = got_q.size() > 0 ? got_q.pop_front() : mk(-1, -1);
         chk("ev_code", g.code, e.code);
`ifndef KEY_EVENT_FIFO_EN
         chk("ev_time", g.t, e.t);
`endif
      end
      chk("ev_extra", got_q.size(), 0);
   endtask

   task automatic run_scan(input bit ev);
      model_scan();
      repeat (30) @(negedge HCLK);
      chk("result", result, mstate);
      if (ev) check_events();
   endtask

   task automatic walk(input int n);
      logic [4:0] one, xexp;
      one = 5'b00001;
      for (int i = 0; i < n; i++) begin
         xexp = ~(one << ((i / 6) % 5));
         chk("btn_x_walk", btn_x, xexp);
         @(negedge HCLK);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      HRESETn = 1'b1;
      #1 HRESETn = 1'b0;
      repeat (2) @(negedge HCLK);
      chk("rst_btn_x", btn_x, 5'b11110);
      chk("rst_result", result, 0);
      chk("rst_key_valid", key_valid, 0);
      chk("rst_key_code", key_code, 0);
      chk("rst_key_ovf", key_ovf, 0);
      HRESETn = 1'b1;
      clear_model();
      walk(36);
      chk("walk_result", result, 0);
      chk("walk_events", got_q.size(), 0);

      do_reset();
      pressed[14] = 1'b1;
      for (int s = 0; s < 4; s++) begin
         run_scan(1'b1);
         if (s == 2) chk("r14_before", result[14], 1'b0);
      end
      chk("r14_rise", result[14], 1'b1);
      pressed[14] = 1'b0;
      for (int s = 0; s < 4; s++) run_scan(1'b1);
      chk("r14_fall", result[14], 1'b0);

      for (int s = 0; s < 10; s++) begin
         pressed[0] = s % 2 == 0;
         run_scan(1'b1);
      end
      pressed[0] = 1'b0;
      chk("bounce_r0", result[0], 1'b0);

      do_reset();
      pressed[16] = 1'b1;
      pressed[17] = 1'b1;
      pressed[19] = 1'b1;
      for (int s = 0; s < 5; s++) run_scan(1'b1);
      pressed = '0;
      for (int s = 0; s < 4; s++) run_scan(1'b1);

      do_reset();
      for (int s = 0; s < 12; s++) begin
         for (int k = 0; k < 20; k++)
            if ($urandom_range(5) == 0) pressed[k] = ~pressed[k];
         run_scan(1'b1);
      end
      pressed = '0;
      for (int s = 0; s < 5; s++) run_scan(1'b1);

`ifdef KEY_EVENT_FIFO_EN
      do_reset();
      hold_pop = 1'b1;
      pressed = 20'h001FF;
      for (int s = 0; s < 4; s++) run_scan(1'b0);
      chk("ovf_set", key_ovf, 1'b1);
      chk("fifo_valid", key_valid, 1'b1);
      chk("fifo_head", key_code, 0);
      pressed = '0;
      void'(exp_q.pop_back());
      hold_pop = 1'b0;
      repeat (10) @(negedge HCLK);
      chk("fifo_popped", got_q.size(), 8);
      check_events();
      chk("fifo_empty", key_valid, 1'b0);
      chk("ovf_sticky", key_ovf, 1'b1);
`else
      chk("ovf_zero", key_ovf, 1'b0);
`endif

      do_reset();
      pressed[5] = 1'b1;
      for (int s = 0; s < 4; s++) run_scan(1'b1);
      repeat (13) @(negedge HCLK);
      chk("mid_pre_result", result[5], 1'b1);
      #2 HRESETn = 1'b0;
      #1;
      chk("mid_btn_x", btn_x, 5'b11110);
      chk("mid_result", result, 0);
      chk("mid_key_valid", key_valid, 0);
      chk("mid_key_code", key_code, 0);
      chk("mid_key_ovf", key_ovf, 0);
      pressed = '0;
      @(negedge HCLK);
      HRESETn = 1'b1;
      clear_model();
      walk(13);
      chk("mid_events", got_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
